// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- eight-channel PWM duty meter with 8-digit seven-segment readout.
//
// Each channel is sampled once per sample tick (every SAMPLE_DIV clocks).
// Every 100 ticks the per-channel high count is latched as duty[ch]
// (0..100 %). The displayed channel sel advances after HOLD_WINDOWS
// completed windows. Digit 7 shows sel, and digits 2..0 show duty[sel]
// with leading zeros blanked.
//
// Ports:
//   CLK100MHZ       in   1   sole clock, rising edge
//   reset           in   1   asynchronous, active-high
//   pwm_in          in   8   PWM channels, asynchronous to the clock
//   SegmentDrivers  out  8   digit anodes, active-low, bit 0 = rightmost
//   SevenSegment    out  8   cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   LED             out  16  [7:0] synchronized levels, [15:8] one-hot sel
//
// Build option:
//   TOP_INPUT_SYNC_EN  defined   -> 2-flop input synchronizer (2-clock latency)
//                      undefined -> single input register (1-clock latency)
// ---------------------------------------------------------------------------
module top #(
   parameter int SAMPLE_DIV   = 1000,
   parameter int SCAN_DIV     = 100000,
   parameter int HOLD_WINDOWS = 1000
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic [7:0]  pwm_in,
   output logic [7:0]  SegmentDrivers,
   output logic [7:0]  SevenSegment,
   output logic [15:0] LED
);

   localparam int SW = $clog2(SAMPLE_DIV + 1);
   localparam int CW = $clog2(SCAN_DIV + 1);
   localparam int HW = $clog2(HOLD_WINDOWS + 1);
   localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_WINDOWS - 1);

   // ---------------- input capture ----------------
   logic [7:0] sync_q;
`ifdef TOP_INPUT_SYNC_EN
   logic [7:0] meta_q;
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= pwm_in;
         sync_q <= meta_q;
      end
   end
`else
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= pwm_in;
   end
`endif

   // ---------------- sample tick ----------------
   logic [SW-1:0] sdiv;
   logic          tick;
   assign tick = (sdiv == S_LAST);

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset)     sdiv <= '0;
      else if (tick) sdiv <= '0;
      else           sdiv <= sdiv + SW'(1);
   end

   // ---------------- duty measurement ----------------
   logic [6:0]      tcnt;
   logic [7:0][6:0] acc;
   logic [7:0][6:0] duty;
   logic [HW-1:0]   wcnt;
   logic [2:0]      sel, sel_nxt;
   logic            win_end, adv;

   assign win_end = tick && (tcnt == 7'd99);
   assign adv     = win_end && (wcnt == H_LAST);
   assign sel_nxt = adv ? sel + 3'd1 : sel;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
         acc  <= '0;
         duty <= '0;
         wcnt <= '0;
         sel  <= '0;
      end else begin
         if (tick) begin
            tcnt <= win_end ? 7'd0 : tcnt + 7'd1;
            for (int ch = 0; ch < 8; ch++) begin
               // The closing tick's own sample belongs to the finished window.
               if (win_end) begin
                  duty[ch] <= acc[ch] + {6'b0, sync_q[ch]};
                  acc[ch]  <= '0;
               end else begin
                  acc[ch]  <= acc[ch] + {6'b0, sync_q[ch]};
               end
            end
         end
         if (win_end) wcnt <= adv ? '0 : wcnt + HW'(1);
         sel <= sel_nxt;
      end
   end

   // ---------------- digit scan ----------------
   logic [CW-1:0] scnt;
   logic [2:0]    dig;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         scnt <= '0;
         dig  <= '0;
      end else if (scnt == C_LAST) begin
         scnt <= '0;
         dig  <= dig + 3'd1;
      end else begin
         scnt <= scnt + CW'(1);
      end
   end

   // ---------------- digit contents ----------------
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   logic [6:0] dsel, tens_w, units_w;
   logic       hund;
   logic [7:0] seg_nxt;

   assign dsel    = duty[sel];
   assign hund    = (dsel >= 7'd100);
   assign tens_w  = (dsel % 7'd100) / 7'd10;
   assign units_w = dsel % 7'd10;

   always_comb begin
      seg_nxt = 8'hFF;
      case (dig)
         3'd0: seg_nxt = seg7(units_w[3:0]);
         3'd1: if (hund || tens_w != 7'd0) seg_nxt = seg7(tens_w[3:0]);
         3'd2: if (hund) seg_nxt = seg7(4'd1);
         3'd7: seg_nxt = seg7({1'b0, sel});
         default: seg_nxt = 8'hFF;
      endcase
   end

   // ---------------- registered outputs ----------------
   logic [7:0] led_sel;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         SegmentDrivers <= 8'hFF;
         SevenSegment   <= 8'hFF;
         led_sel        <= '0;
      end else begin
         SegmentDrivers <= ~(8'b1 << dig);
         SevenSegment   <= seg_nxt;
         // Track sel's next value so the one-hot moves on the advance edge.
         led_sel        <= 8'b1 << sel_nxt;
      end
   end

   // Both halves come straight from flops.
   assign LED = {led_sel, sync_q};

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- self-checking bench for top (SAMPLE_DIV=1, SCAN_DIV=4,
// HOLD_WINDOWS=1: one tick per clock, 100-clock windows, sel advances
// every window). A reference model tracks edges since reset, the applied
// input history, per-window high counts and the displayed channel, and
// predicts every output after every clock.
// ---------------------------------------------------------------------------
module tb_top;
   localparam int SD = 1;
   localparam int SC = 4;
   localparam int HWIN = 1;
`ifdef TOP_INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pwm;
   logic [7:0]  an, seg;
   logic [15:0] led;

   top #(.SAMPLE_DIV(SD), .SCAN_DIV(SC), .HOLD_WINDOWS(HWIN)) dut (
      .CLK100MHZ(clk), .reset(rst), .pwm_in(pwm),
      .SegmentDrivers(an), .SevenSegment(seg), .LED(led)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model state
   int         k;
   logic [7:0] pq[$];
   int         ones[8];
   int         duty_m[8];
   int         sel_m;

   function automatic logic [7:0] code(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input int dg, input int s, input int du);
      case (dg)
         0: return code(du % 10);
         1: return (du >= 10)  ? code((du / 10) % 10) : 8'hFF;
         2: return (du >= 100) ? code(du / 100) : 8'hFF;
         7: return code(s);
         default: return 8'hFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      pq.delete();
      pq.push_back(8'h00);   // capture flops hold 0 out of reset
      for (int c = 0; c < 8; c++) begin
         ones[c] = 0;
         duty_m[c] = 0;
      end
      sel_m = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_an"},  {8'h0, an},  16'h00FF);
      chk({tag, "_seg"}, {8'h0, seg}, 16'h00FF);
      chk({tag, "_led"}, led,         16'h0000);
   endtask

   // Apply v before the next edge, advance the model by one edge, check all outputs.
   task automatic step(input logic [7:0] v);
      int dg, ds, dd;
      logic [7:0] smp;
      pwm = v;
      pq.push_back(v);
      @(posedge clk);
      k++;
      // display reflects state held before this edge
      dg = ((k - 1) / SC) % 8;
      ds = sel_m;
      dd = duty_m[sel_m];
      smp = (k - LAT >= 1) ? pq[k - LAT] : 8'h00;
      for (int c = 0; c < 8; c++) ones[c] += int'(smp[c]);
      if (k % 100 == 0) begin
         for (int c = 0; c < 8; c++) begin
            duty_m[c] = ones[c];
            ones[c] = 0;
         end
         sel_m = (sel_m + 1) % 8;
      end
      #1;
      chk("anode",   {8'h0, an},        {8'h0, ~(8'b1 << dg)});
      chk("segment", {8'h0, seg},       {8'h0, exp_seg(dg, ds, dd)});
      chk("led_lo",  {8'h0, led[7:0]},  {8'h0, pq[k - LAT + 1]});
      chk("led_hi",  {8'h0, led[15:8]}, {8'h0, 8'(1 << sel_m)});
   endtask

   initial begin
      logic [7:0] v;
      rst = 1'b1;
      pwm = 8'h5A;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset_hold");

      rst = 1'b0;
      model_reset();

      // all channels low for a full window
      repeat (100) step(8'h00);

      // ch0 constant high, ch1 toggling, ch7 low, ch2..6 random
      repeat (800) begin
         v = 8'($urandom);
         v[0] = 1'b1;
         v[1] = 1'(k % 2);
         v[7] = 1'b0;
         step(v);
      end
      repeat (37) step(8'($urandom));

      // asynchronous reset mid-window
      rst = 1'b1;
      #1;
      chk_reset_outputs("reset_async");
      @(posedge clk);
      #1;
      chk_reset_outputs("reset_held");
      rst = 1'b0;
      model_reset();

      repeat (250) step(8'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
